// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller: sequences the random generator (reset, seed,
// warm-up, play), counts hits and misses, and runs the round countdown.
module mole_game_ctrl #(
    parameter int GAME_SECONDS = 30,
    parameter int WARM_CYCLES  = 480
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       tick_1hz,
    input  logic [7:0] mole,
    input  logic [7:0] hit,
    output logic       Rreset,
    output logic       Rload_lfsr,
    output logic       Rshift,
    output logic       Rspeed,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [5:0] time_left,
    output logic       busy,
    output logic       game_over
);

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_SEED = 3'd2;
    localparam logic [2:0] ST_WARM = 3'd3;
    localparam logic [2:0] ST_PLAY = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [5:0] GAME_TIME = 6'(GAME_SECONDS);
    localparam logic [9:0] WARM_LAST = 10'(WARM_CYCLES - 1);

    logic [2:0] state_r;
    logic [2:0] state_s;
    logic       start_q_r;
    logic [7:0] hit_q_r;
    logic [9:0] warm_cnt_r;
    logic       start_rise_s;
    logic [7:0] hit_rise_s;
    logic       final_tick_s;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign start_rise_s = start & ~start_q_r;
    assign hit_rise_s   = hit & ~hit_q_r;
    assign final_tick_s = tick_1hz && (time_left == 6'd1);

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: state_s = ST_IDLE;
            ST_IDLE: begin
                if (start_rise_s) state_s = ST_SEED;
                else              state_s = ST_IDLE;
            end
            ST_SEED: state_s = ST_WARM;
            ST_WARM: begin
                if (warm_cnt_r == 10'd0) state_s = ST_PLAY;
                else                     state_s = ST_WARM;
            end
            ST_PLAY: begin
                if (final_tick_s) state_s = ST_DONE;
                else              state_s = ST_PLAY;
            end
            ST_DONE: begin
                if (start_rise_s) state_s = ST_SEED;
                else              state_s = ST_DONE;
            end
            default: state_s = ST_INIT;
        endcase
    end

    // State, edge-detect history and warm-up counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            start_q_r  <= 1'b0;
            hit_q_r    <= 8'h00;
            warm_cnt_r <= 10'd0;
        end else begin
            state_r   <= state_s;
            start_q_r <= start;
            hit_q_r   <= hit;
            if (state_r == ST_SEED)                         warm_cnt_r <= WARM_LAST;
            else if (state_r == ST_WARM && warm_cnt_r != 10'd0) warm_cnt_r <= warm_cnt_r - 10'd1;
            else                                            warm_cnt_r <= warm_cnt_r;
        end
    end

    // Strobes decoded from the upcoming state so they line up with state_r
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            Rreset     <= 1'b1;
            Rload_lfsr <= 1'b0;
            Rshift     <= 1'b0;
            Rspeed     <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            Rreset     <= (state_s == ST_INIT);
            Rload_lfsr <= (state_s == ST_SEED);
            Rshift     <= (state_s == ST_WARM) || (state_s == ST_PLAY);
            Rspeed     <= (state_s == ST_PLAY);
            busy       <= (state_s == ST_SEED) || (state_s == ST_WARM) || (state_s == ST_PLAY);
            game_over  <= (state_s == ST_DONE);
        end
    end

    // Round counters; a hit landing with the final tick is still credited
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            score     <= 8'h00;
            misses    <= 8'h00;
            time_left <= 6'd0;
        end else if ((state_r == ST_IDLE || state_r == ST_DONE) && start_rise_s) begin
            score     <= 8'h00;
            misses    <= 8'h00;
            time_left <= GAME_TIME;
        end else if (state_r == ST_PLAY) begin
            score  <= sat_add8(score, popcount8(hit_rise_s & mole));
            misses <= sat_add8(misses, popcount8(hit_rise_s & ~mole));
            if (tick_1hz && time_left != 6'd0) time_left <= time_left - 6'd1;
            else                               time_left <= time_left;
        end else begin
            score     <= score;
            misses    <= misses;
            time_left <= time_left;
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with a 3-second round and 4-cycle warm-up.
module tb_mole_game_ctrl;

    logic       CLOCK_50;
    logic       reset;
    logic       start;
    logic       tick_1hz;
    logic [7:0] mole;
    logic [7:0] hit;
    logic       Rreset;
    logic       Rload_lfsr;
    logic       Rshift;
    logic       Rspeed;
    logic [7:0] score;
    logic [7:0] misses;
    logic [5:0] time_left;
    logic       busy;
    logic       game_over;

    int tests_run;
    int tests_failed;

    mole_game_ctrl #(.GAME_SECONDS(3), .WARM_CYCLES(4)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .tick_1hz  (tick_1hz),
        .mole      (mole),
        .hit       (hit),
        .Rreset    (Rreset),
        .Rload_lfsr(Rload_lfsr),
        .Rshift    (Rshift),
        .Rspeed    (Rspeed),
        .score     (score),
        .misses    (misses),
        .time_left (time_left),
        .busy      (busy),
        .game_over (game_over)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset    = 1'b1;
        start    = 1'b0;
        tick_1hz = 1'b0;
        mole     = 8'h00;
        hit      = 8'h00;
        step();
        step();
        check_val("rst_Rreset", 32'(Rreset), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_time", 32'(time_left), 32'd0);
        check_val("rst_over", 32'(game_over), 32'd0);

        // release: INIT holds Rreset for one cycle, then IDLE
        reset = 1'b0;
        check_val("init_Rreset", 32'(Rreset), 32'd1);
        step();
        check_val("idle_Rreset", 32'(Rreset), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);

        start = 1'b1;
        step();
        check_val("seed_load", 32'(Rload_lfsr), 32'd1);
        check_val("seed_shift", 32'(Rshift), 32'd0);
        check_val("seed_time", 32'(time_left), 32'd3);
        check_val("seed_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("warm_load", 32'(Rload_lfsr), 32'd0);
            check_val("warm_shift", 32'(Rshift), 32'd1);
            check_val("warm_speed", 32'(Rspeed), 32'd0);
        end
        step();
        check_val("play_speed", 32'(Rspeed), 32'd1);
        check_val("play_shift", 32'(Rshift), 32'd1);
        check_val("play_time", 32'(time_left), 32'd3);
        check_val("play_busy", 32'(busy), 32'd1);

        // two lit holes and one unlit hole struck together
        mole = 8'h81;
        hit  = 8'h83;
        step();
        check_val("hit_score", 32'(score), 32'd2);
        check_val("hit_miss", 32'(misses), 32'd1);
        step();
        check_val("hold_score", 32'(score), 32'd2);
        check_val("hold_miss", 32'(misses), 32'd1);
        hit = 8'h00;
        step();

        // start edge in PLAY is ignored
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check_val("pstart_score", 32'(score), 32'd2);
        check_val("pstart_load", 32'(Rload_lfsr), 32'd0);
        check_val("pstart_speed", 32'(Rspeed), 32'd1);

        // climb to 250, then 254, then saturate
        mole = 8'hFF;
        for (int i = 0; i < 31; i++) begin
            hit = 8'hFF;
            step();
            hit = 8'h00;
            step();
        end
        check_val("score_250", 32'(score), 32'd250);
        mole = 8'h0F;
        hit  = 8'h0F;
        step();
        check_val("score_254", 32'(score), 32'd254);
        hit = 8'h00;
        step();
        mole = 8'hFF;
        hit  = 8'hFF;
        step();
        check_val("score_sat", 32'(score), 32'd255);
        hit = 8'h00;
        step();
        hit = 8'hFF;
        step();
        check_val("score_hold_sat", 32'(score), 32'd255);
        check_val("miss_keep", 32'(misses), 32'd1);
        hit = 8'h00;
        step();

        // countdown; final tick coincides with a miss that must count
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check_val("tick1_time", 32'(time_left), 32'd2);
        step();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check_val("tick2_time", 32'(time_left), 32'd1);
        check_val("tick2_over", 32'(game_over), 32'd0);
        step();
        mole     = 8'h00;
        hit      = 8'h02;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check_val("done_time", 32'(time_left), 32'd0);
        check_val("done_over", 32'(game_over), 32'd1);
        check_val("done_shift", 32'(Rshift), 32'd0);
        check_val("done_speed", 32'(Rspeed), 32'd0);
        check_val("done_busy", 32'(busy), 32'd0);
        check_val("final_miss", 32'(misses), 32'd2);

        // DONE ignores ticks and hits
        hit = 8'h00;
        step();
        hit      = 8'hFF;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check_val("dhold_score", 32'(score), 32'd255);
        check_val("dhold_miss", 32'(misses), 32'd2);
        check_val("dhold_time", 32'(time_left), 32'd0);
        check_val("dhold_over", 32'(game_over), 32'd1);

        // restart from DONE
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check_val("rs_score", 32'(score), 32'd0);
        check_val("rs_miss", 32'(misses), 32'd0);
        check_val("rs_time", 32'(time_left), 32'd3);
        check_val("rs_load", 32'(Rload_lfsr), 32'd1);
        check_val("rs_over", 32'(game_over), 32'd0);
        step();
        step();
        check_val("rs_warm_shift", 32'(Rshift), 32'd1);

        // asynchronous abort in WARM
        reset = 1'b1;
        #1;
        check_val("abort_Rreset", 32'(Rreset), 32'd1);
        check_val("abort_shift", 32'(Rshift), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_time", 32'(time_left), 32'd0);
        step();
        reset = 1'b0;
        check_val("rel_Rreset", 32'(Rreset), 32'd1);
        step();
        check_val("rel_idle_Rreset", 32'(Rreset), 32'd0);
        check_val("rel_idle_busy", 32'(busy), 32'd0);
        // start held through release is not an edge
        step();
        check_val("held_start_load", 32'(Rload_lfsr), 32'd0);
        check_val("held_start_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
